// File: rtl/pc_branch_unit_pkg.sv
// Shared types for pc_branch_unit: control-flow class encodings produced by the
// decoder and the PC-owner FSM state encoding.
package pc_branch_unit_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_type_e;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  localparam logic [31:0] InstBytes = 32'd4;

endpackage

// File: rtl/pc_branch_unit_if.sv
// ALU result/flag interface between the decoder/ALU (master) and the PC owner
// (slave).
//   br_type    : control-flow class (raw 4-bit, unused encodings allowed)
//   zero       : ALU zero flag (meaningful while ALU does SUB)
//   less_than  : ALU less-than flag (meaningful while ALU does SLT/SLTU)
//   alu_result : rs1+imm, the JALR target
//   imm        : sign-extended B/J immediate
interface pc_branch_unit_if;

  logic [3:0]  br_type;
  logic        zero;
  logic        less_than;
  logic [31:0] alu_result;
  logic [31:0] imm;

  modport master (
    output br_type,
    output zero,
    output less_than,
    output alu_result,
    output imm
  );

  modport slave (
    input br_type,
    input zero,
    input less_than,
    input alu_result,
    input imm
  );

endinterface

// File: rtl/pc_branch_unit_branch_cond.sv
// Combinational taken/target resolver.
//   br_type_i    : control-flow class
//   zero_i       : ALU zero flag
//   less_than_i  : ALU less-than flag (signedness already chosen by SLT/SLTU)
//   alu_result_i : JALR target before bit0 clear
//   imm_i        : B/J immediate
//   pc_i         : current PC
//   taken_o      : control transfer happens
//   target_o     : destination when taken
module pc_branch_unit_branch_cond
  import pc_branch_unit_pkg::*;
(
  input  logic [3:0]  br_type_i,
  input  logic        zero_i,
  input  logic        less_than_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] pc_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic [31:0] pc_rel;

  // Wraps modulo 2^32 by construction.
  assign pc_rel = pc_i + imm_i;

  always_comb begin
    taken_o  = 1'b0;
    target_o = pc_rel;
    case (br_type_i)
      BR_BEQ:          taken_o = zero_i;
      BR_BNE:          taken_o = ~zero_i;
      BR_BLT, BR_BLTU: taken_o = less_than_i;
      BR_BGE, BR_BGEU: taken_o = ~less_than_i;
      BR_JAL:          taken_o = 1'b1;
      BR_JALR: begin
        taken_o  = 1'b1;
        target_o = alu_result_i & ~32'h1;
      end
      default:         taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// PC owner of the single-cycle core: resolves branches/jumps from ALU flags,
// updates the PC, pulses redirect after a taken update and halts on a target
// whose bit1 is set.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   stall       : freeze PC/FSM this cycle (inputs ignored)
//   alu_if      : ALU result/flag interface (slave side)
//   pc          : current PC (registered)
//   pc_plus4    : pc+4 link value (combinational)
//   inst_valid  : current pc is executing (RUN)
//   redirect    : one-cycle pulse, coincident with a taken PC update
//   halted      : in HALT
//   trap_pc     : PC of the instruction with the misaligned target
// Optional build macro PC_BRANCH_STATS_EN adds saturating counters
//   br_count (non-NONE instructions evaluated) and taken_count (of those, taken).
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  pc_branch_unit_if.slave alu_if,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            inst_valid,
  output logic            redirect,
  output logic            halted,
  output logic [XLEN-1:0] trap_pc
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     taken_count
`endif
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
  logic              redirect_q, redirect_d;
  logic              taken;
  logic [XLEN-1:0]   target;
  logic              evaluate;

  pc_branch_unit_branch_cond u_branch_cond (
    .br_type_i    (alu_if.br_type),
    .zero_i       (alu_if.zero),
    .less_than_i  (alu_if.less_than),
    .alu_result_i (alu_if.alu_result),
    .imm_i        (alu_if.imm),
    .pc_i         (pc_q),
    .taken_o      (taken),
    .target_o     (target)
  );

  // An instruction is consumed only in RUN on a non-stalled cycle.
  assign evaluate = (state_q == StRun) && !stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    trap_pc_d  = trap_pc_q;
    redirect_d = 1'b0;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (!stall) begin
          if (taken) begin
            if (target[1]) begin
              state_d   = StHalt;
              trap_pc_d = pc_q;
            end else begin
              pc_d       = target;
              redirect_d = 1'b1;
            end
          end else begin
            pc_d = pc_q + InstBytes;
          end
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      trap_pc_q  <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      trap_pc_q  <= trap_pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc         = pc_q;
  assign pc_plus4   = pc_q + InstBytes;
  assign inst_valid = (state_q == StRun);
  assign halted     = (state_q == StHalt);
  assign redirect   = redirect_q;
  assign trap_pc    = trap_pc_q;

`ifdef PC_BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] taken_count_q, taken_count_d;

  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (evaluate && (alu_if.br_type != BR_NONE)) begin
      if (br_count_q != 32'hFFFF_FFFF) br_count_d = br_count_q + 32'd1;
      // Misaligned traps still count as taken.
      if (taken && (taken_count_q != 32'hFFFF_FFFF)) taken_count_d = taken_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`else
  logic unused_evaluate;
  assign unused_evaluate = evaluate;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;
  import pc_branch_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        redirect;
  logic        halted;
  logic [31:0] trap_pc;
`ifdef PC_BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] taken_count;
`endif

  int total = 0;
  int bad   = 0;

  pc_branch_unit_if alu_if ();

  pc_branch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .alu_if     (alu_if),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .inst_valid (inst_valid),
    .redirect   (redirect),
    .halted     (halted),
    .trap_pc    (trap_pc)
`ifdef PC_BRANCH_STATS_EN
    ,
    .br_count    (br_count),
    .taken_count (taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] bt, input logic z, input logic lt,
                       input logic [31:0] alu, input logic [31:0] im);
    alu_if.br_type    = bt;
    alu_if.zero       = z;
    alu_if.less_than  = lt;
    alu_if.alu_result = alu;
    alu_if.imm        = im;
  endtask

  // Advance one rising edge and sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Jump to an aligned address through JALR, then go idle.
  task automatic goto_pc(input logic [31:0] addr);
    drive(BR_JALR, 1'b0, 1'b0, addr, 32'h0);
    step();
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h100); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
    total++; if (redirect !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", redirect, halted); end
    total++; if (trap_pc !== 32'h0) begin bad++; $display("FAIL reset_trap_pc got=%h exp=0", trap_pc); end
    // BOOT consumes one edge with pc held, even with a branch on the inputs.
    drive(BR_JAL, 1'b0, 1'b0, 32'h0, 32'h40);
    step();
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (pc !== 32'h100 || inst_valid !== 1'b1) begin bad++; $display("FAIL boot_to_run got pc=%h iv=%b exp pc=100 iv=1", pc, inst_valid); end
  endtask

  task automatic test_sequential();
    step();
    total++; if (pc !== 32'h104) begin bad++; $display("FAIL seq_1 got=%h exp=104", pc); end
    step();
    total++; if (pc !== 32'h108 || redirect !== 1'b0) begin bad++; $display("FAIL seq_2 got pc=%h rd=%b exp pc=108 rd=0", pc, redirect); end
  endtask

  task automatic test_cond_branches();
    goto_pc(32'h200);
    drive(BR_BEQ, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF0);
    step();
    total++; if (pc !== 32'h1F0 || redirect !== 1'b1) begin bad++; $display("FAIL beq_taken got pc=%h rd=%b exp pc=1f0 rd=1", pc, redirect); end
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    total++; if (pc !== 32'h1F4 || redirect !== 1'b0) begin bad++; $display("FAIL redirect_pulse got pc=%h rd=%b exp pc=1f4 rd=0", pc, redirect); end
    goto_pc(32'h200);
    drive(BR_BEQ, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF0);
    step();
    total++; if (pc !== 32'h204 || redirect !== 1'b0) begin bad++; $display("FAIL beq_not_taken got pc=%h rd=%b exp pc=204 rd=0", pc, redirect); end
    drive(BR_BNE, 1'b0, 1'b0, 32'h0, 32'h10);
    step();
    total++; if (pc !== 32'h214) begin bad++; $display("FAIL bne_taken got=%h exp=214", pc); end
    drive(BR_BLT, 1'b0, 1'b1, 32'h0, 32'h8);
    step();
    total++; if (pc !== 32'h21C) begin bad++; $display("FAIL blt_taken got=%h exp=21c", pc); end
    drive(BR_BGE, 1'b0, 1'b1, 32'h0, 32'h40);
    step();
    total++; if (pc !== 32'h220) begin bad++; $display("FAIL bge_not_taken got=%h exp=220", pc); end
    drive(BR_BGEU, 1'b0, 1'b0, 32'h0, 32'h40);
    step();
    total++; if (pc !== 32'h260) begin bad++; $display("FAIL bgeu_taken got=%h exp=260", pc); end
    drive(4'hF, 1'b1, 1'b1, 32'h0, 32'h40);
    step();
    total++; if (pc !== 32'h264 || redirect !== 1'b0) begin bad++; $display("FAIL unused_enc got pc=%h rd=%b exp pc=264 rd=0", pc, redirect); end
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_jalr();
    goto_pc(32'h300);
    drive(BR_JALR, 1'b0, 1'b0, 32'h1235, 32'h0);
    #1;
    total++; if (pc_plus4 !== 32'h304) begin bad++; $display("FAIL jalr_link got=%h exp=304", pc_plus4); end
    step();
    total++; if (pc !== 32'h1234 || redirect !== 1'b1) begin bad++; $display("FAIL jalr_target got pc=%h rd=%b exp pc=1234 rd=1", pc, redirect); end
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    goto_pc(32'h600);
    drive(BR_JAL, 1'b0, 1'b0, 32'h0, 32'h10);
    step();
    total++; if (pc !== 32'h610 || redirect !== 1'b1) begin bad++; $display("FAIL b2b_first got pc=%h rd=%b exp pc=610 rd=1", pc, redirect); end
    step();
    total++; if (pc !== 32'h620 || redirect !== 1'b1) begin bad++; $display("FAIL b2b_second got pc=%h rd=%b exp pc=620 rd=1", pc, redirect); end
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    total++; if (pc !== 32'h624 || redirect !== 1'b0) begin bad++; $display("FAIL b2b_end got pc=%h rd=%b exp pc=624 rd=0", pc, redirect); end
  endtask

  task automatic test_stall();
    goto_pc(32'h500);
    drive(BR_BLTU, 1'b0, 1'b1, 32'h0, 32'h20);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 32'h500 || redirect !== 1'b0) begin bad++; $display("FAIL stall_hold_%0d got pc=%h rd=%b exp pc=500 rd=0", i, pc, redirect); end
    end
    stall = 1'b0;
    step();
    total++; if (pc !== 32'h520 || redirect !== 1'b1) begin bad++; $display("FAIL stall_release got pc=%h rd=%b exp pc=520 rd=1", pc, redirect); end
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4 got=%h exp=0", pc_plus4); end
    step();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", pc); end
  endtask

  task automatic test_halt();
    goto_pc(32'h400);
    drive(BR_JAL, 1'b0, 1'b0, 32'h0, 32'h6);
    step();
    total++; if (halted !== 1'b1 || inst_valid !== 1'b0) begin bad++; $display("FAIL halt_state got h=%b iv=%b exp h=1 iv=0", halted, inst_valid); end
    total++; if (trap_pc !== 32'h400 || pc !== 32'h400) begin bad++; $display("FAIL halt_pc got trap=%h pc=%h exp 400/400", trap_pc, pc); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL halt_redirect got=%b exp=0", redirect); end
    drive(BR_JALR, 1'b0, 1'b0, 32'h800, 32'h0);
    repeat (2) step();
    total++; if (pc !== 32'h400 || halted !== 1'b1 || trap_pc !== 32'h400) begin bad++; $display("FAIL halt_absorb got pc=%h h=%b trap=%h", pc, halted, trap_pc); end
    // Asynchronous reset in the middle of a cycle.
    #2 rst_n = 1'b0;
    #1;
    total++; if (pc !== 32'h100 || halted !== 1'b0 || trap_pc !== 32'h0) begin bad++; $display("FAIL async_reset got pc=%h h=%b trap=%h exp 100/0/0", pc, halted, trap_pc); end
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    total++; if (pc !== 32'h104 || inst_valid !== 1'b1) begin bad++; $display("FAIL restart got pc=%h iv=%b exp pc=104 iv=1", pc, inst_valid); end
  endtask

`ifdef PC_BRANCH_STATS_EN
  task automatic test_stats();
    apply_reset();
    total++; if (br_count !== 32'h0 || taken_count !== 32'h0) begin bad++; $display("FAIL stats_reset got %0d/%0d exp 0/0", br_count, taken_count); end
    step();  // BOOT
    drive(BR_BEQ, 1'b1, 1'b0, 32'h0, 32'h10); step();  // taken
    drive(BR_BNE, 1'b1, 1'b0, 32'h0, 32'h10); step();  // not taken
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0); step();  // not counted
    drive(BR_BEQ, 1'b1, 1'b0, 32'h0, 32'h10);
    stall = 1'b1; step(); stall = 1'b0;               // stalled, not counted
    drive(BR_BLT, 1'b0, 1'b1, 32'h0, 32'h8); step();  // taken
    drive(BR_BGEU, 1'b0, 1'b1, 32'h0, 32'h8); step(); // not taken
    drive(BR_JAL, 1'b0, 1'b0, 32'h0, 32'h20); step(); // taken
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0); step();
    total++; if (br_count !== 32'd5) begin bad++; $display("FAIL stats_br got=%0d exp=5", br_count); end
    total++; if (taken_count !== 32'd3) begin bad++; $display("FAIL stats_taken got=%0d exp=3", taken_count); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    drive(BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_sequential();
    test_cond_branches();
    test_jalr();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_halt();
`ifdef PC_BRANCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
